// File: rtl/clock_crossing_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_crossing_io_pkg
//  Purpose  : Shared types and sizing for the clock_crossing_io slave-side
//             burst adapter: FSM state encoding, bus widths, read throttle
//             limit and a burstcount normalisation helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package clock_crossing_io_pkg;

    localparam int ADDR_W      = 5;   // word address toward the bridge
    localparam int DATA_W      = 32;
    localparam int BE_W        = DATA_W / 8;
    localparam int BURST_W     = 4;   // burstcount width
    localparam int MAX_PENDING = 15;  // reads issued but not yet returned
    localparam int PEND_W      = 5;   // holds 0..MAX_PENDING

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_WR_BEAT  = 2'd2,
        ST_WR_WAIT  = 2'd3
    } state_t;

    // A burstcount of zero is treated as a single beat.
    function automatic logic [BURST_W-1:0] eff_burstcount(input logic [BURST_W-1:0] bc);
        return (bc == '0) ? BURST_W'(1) : bc;
    endfunction

endpackage : clock_crossing_io_pkg
`default_nettype wire

// File: rtl/clock_crossing_io_burst_adapter_if.sv
`default_nettype none
// ============================================================================
//  Module   : clock_crossing_io_burst_adapter_if
//  Purpose  : Avalon-MM style bus bundle. Used once on the upstream (burst)
//             side and once on the downstream (single-word bridge) side.
//  Signals  : address, burstcount, read, write, writedata, byteenable
//             (master -> slave); waitrequest, readdata, readdatavalid
//             (slave -> master).
//  Modports : master, slave
//  Revision : 1.0  initial release
// ============================================================================
interface clock_crossing_io_burst_adapter_if
    import clock_crossing_io_pkg::*;
#(
    parameter int AW = ADDR_W + 2,
    parameter int DW = DATA_W,
    parameter int BW = BURST_W
);
    logic [AW-1:0]   address;
    logic [BW-1:0]   burstcount;
    logic            read;
    logic            write;
    logic [DW-1:0]   writedata;
    logic [DW/8-1:0] byteenable;
    logic            waitrequest;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;

    modport master (
        output address, burstcount, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, burstcount, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface : clock_crossing_io_burst_adapter_if
`default_nettype wire

// File: rtl/clock_crossing_io_pending_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : clock_crossing_io_pending_ctr
//  Purpose  : Up/down saturating counter of reads issued to the bridge but
//             not yet answered, plus the remaining headroom.
//  Ports    : slave_clk, slave_reset_n (async, active-low)
//             i_inc      read beat accepted by the bridge
//             i_dec      read response returned
//             o_pending  outstanding reads
//             o_room     MAX_PENDING - o_pending
//  Revision : 1.0  initial release
// ============================================================================
module clock_crossing_io_pending_ctr
    import clock_crossing_io_pkg::*;
(
    input  wire logic              slave_clk,
    input  wire logic              slave_reset_n,
    input  wire logic              i_inc,
    input  wire logic              i_dec,
    output logic [PEND_W-1:0]      o_pending,
    output logic [PEND_W-1:0]      o_room
);
    localparam logic [PEND_W-1:0] c_MAX = PEND_W'(MAX_PENDING);

    logic [PEND_W-1:0] r_pending;

    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            r_pending <= '0;
        end else begin
            // Simultaneous issue and return leaves the count unchanged.
            case ({i_inc, i_dec})
                2'b10:   if (r_pending != c_MAX) r_pending <= r_pending + 1'b1;
                2'b01:   if (r_pending != '0)    r_pending <= r_pending - 1'b1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    // A response with nothing outstanding means the bridge and this counter
    // disagree; the counter holds at zero rather than wrapping.
    always @(posedge slave_clk) begin
        if (slave_reset_n) begin
            assert (!(i_dec && !i_inc && r_pending == '0))
                else $error("pending_ctr: response returned with no read outstanding");
        end
    end

    assign o_pending = r_pending;
    assign o_room    = c_MAX - r_pending;

endmodule : clock_crossing_io_pending_ctr
`default_nettype wire

// File: rtl/clock_crossing_io_burst_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : clock_crossing_io_burst_adapter
//  Purpose  : slave_clk-domain stage upstream of the clock_crossing_io slave
//             port. Splits Avalon-MM burst reads/writes into single-word
//             transfers with an incrementing (wrapping) word address and
//             throttles reads so the bridge response FIFO cannot overflow.
//  Ports    : slave_clk, slave_reset_n (async, active-low)
//             s_bus  slave modport  - burst side from the Nios master
//             m_bus  master modport - single-word side to the bridge
//  Revision : 1.0  initial release
// ============================================================================
module clock_crossing_io_burst_adapter
    import clock_crossing_io_pkg::*;
(
    input  wire logic                        slave_clk,
    input  wire logic                        slave_reset_n,
    clock_crossing_io_burst_adapter_if.slave  s_bus,
    clock_crossing_io_burst_adapter_if.master m_bus
);
    state_t              r_state,     w_state_nxt;
    logic [ADDR_W-1:0]   r_addr,      w_addr_nxt;
    logic [BURST_W-1:0]  r_remaining, w_remaining_nxt;
    logic                r_read,      w_read_nxt;
    logic                r_write,     w_write_nxt;
    logic [BE_W-1:0]     r_be,        w_be_nxt;
    logic [DATA_W-1:0]   r_wdata,     w_wdata_nxt;

    logic                w_accept;
    logic [BURST_W-1:0]  w_bc;
    logic                w_rd_fits;
    logic                w_issue;
    logic [PEND_W-1:0]   w_pending;
    logic [PEND_W-1:0]   w_room;

    assign w_bc      = eff_burstcount(s_bus.burstcount);
    assign w_rd_fits = (PEND_W'(w_bc) <= w_room);
    assign w_issue   = r_read & ~m_bus.waitrequest;

    clock_crossing_io_pending_ctr u_pending (
        .slave_clk     (slave_clk),
        .slave_reset_n (slave_reset_n),
        .i_inc         (w_issue),
        .i_dec         (m_bus.readdatavalid),
        .o_pending     (w_pending),
        .o_room        (w_room)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_remaining_nxt = r_remaining;
        w_read_nxt      = r_read;
        w_write_nxt     = r_write;
        w_be_nxt        = r_be;
        w_wdata_nxt     = r_wdata;
        w_accept        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (s_bus.read && w_rd_fits) begin
                    w_accept        = 1'b1;
                    w_addr_nxt      = s_bus.address[ADDR_W+1:2];
                    w_remaining_nxt = w_bc;
                    w_be_nxt        = s_bus.byteenable;
                    w_read_nxt      = 1'b1;
                    w_state_nxt     = ST_RD_ISSUE;
                end else if (s_bus.write) begin
                    w_accept        = 1'b1;
                    w_addr_nxt      = s_bus.address[ADDR_W+1:2];
                    w_remaining_nxt = w_bc;
                    w_be_nxt        = s_bus.byteenable;
                    w_wdata_nxt     = s_bus.writedata;
                    w_write_nxt     = 1'b1;
                    w_state_nxt     = ST_WR_BEAT;
                end
            end

            ST_RD_ISSUE: begin
                if (!m_bus.waitrequest) begin
                    w_addr_nxt      = r_addr + 1'b1;
                    w_remaining_nxt = r_remaining - 1'b1;
                    if (r_remaining == BURST_W'(1)) begin
                        w_read_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            ST_WR_BEAT: begin
                if (!m_bus.waitrequest) begin
                    w_addr_nxt      = r_addr + 1'b1;
                    w_remaining_nxt = r_remaining - 1'b1;
                    w_write_nxt     = 1'b0;
                    w_state_nxt     = (r_remaining == BURST_W'(1)) ? ST_IDLE : ST_WR_WAIT;
                end
            end

            ST_WR_WAIT: begin
                // The upstream master may pause between beats of a burst.
                if (s_bus.write) begin
                    w_accept    = 1'b1;
                    w_be_nxt    = s_bus.byteenable;
                    w_wdata_nxt = s_bus.writedata;
                    w_write_nxt = 1'b1;
                    w_state_nxt = ST_WR_BEAT;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_remaining <= w_remaining_nxt;
            r_read      <= w_read_nxt;
            r_write     <= w_write_nxt;
            r_be        <= w_be_nxt;
            r_wdata     <= w_wdata_nxt;
        end
    end

    // A read burst larger than the throttle limit could never be accepted.
    always @(posedge slave_clk) begin
        if (slave_reset_n && r_state == ST_IDLE && s_bus.read) begin
            assert (int'(w_bc) <= MAX_PENDING)
                else $error("burst_adapter: read burstcount exceeds MAX_PENDING");
        end
        if (slave_reset_n) begin
            assert (int'(w_pending) <= MAX_PENDING)
                else $error("burst_adapter: pending count out of range");
        end
    end

    // Held high throughout reset, independent of the FSM.
    assign s_bus.waitrequest   = ~slave_reset_n | ~w_accept;
    assign s_bus.readdata      = m_bus.readdata;
    assign s_bus.readdatavalid = m_bus.readdatavalid;

    assign m_bus.address    = r_addr;
    assign m_bus.burstcount = BURST_W'(1);
    assign m_bus.read       = r_read;
    assign m_bus.write      = r_write;
    assign m_bus.writedata  = r_wdata;
    assign m_bus.byteenable = r_be;

endmodule : clock_crossing_io_burst_adapter
`default_nettype wire
